// File: rtl/gearbox_pkg.sv
// Shared widths, constants and FSM encoding for the 67b->20b TX gearbox load scheduler.
package gearbox_pkg;

    localparam int GB_IN_W     = 67;
    localparam int GB_OUT_W    = 20;
    localparam int GB_LVL_W    = 7;
    localparam int GB_LOAD_INC = GB_IN_W - GB_OUT_W;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } gb_state_e;

endpackage

// File: rtl/gearbox_lvl_tracker.sv
// Tracks how many loaded bits the gearbox still has to shift out (0..66) and flags
// when a new 67b load fits (fewer than one output word left) or the gearbox is empty.
module gearbox_lvl_tracker
    import gearbox_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic drain_i,
    output logic slot_ok_o,
    output logic empty_o
);

    logic [GB_LVL_W-1:0] lvl_q;
    logic [GB_LVL_W-1:0] lvl_d;

    // A load cycle also shifts one output word, hence the net +47.
    always_comb begin
        lvl_d = lvl_q;
        if (clr_i) begin
            lvl_d = '0;
        end else if (load_i) begin
            lvl_d = lvl_q + GB_LVL_W'(GB_LOAD_INC);
        end else if (drain_i) begin
            lvl_d = (lvl_q >= GB_LVL_W'(GB_OUT_W)) ? lvl_q - GB_LVL_W'(GB_OUT_W) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign slot_ok_o = (lvl_q < GB_LVL_W'(GB_OUT_W));
    assign empty_o   = (lvl_q == '0);

endmodule

// File: rtl/gearbox_tx_sched.sv
// Load scheduler for the 67b->20b TX gearbox: paces loads, inserts idles, owns gearbox reset.
// Statistics counters are built only when GEARBOX_SCHED_STATS_EN is defined.
module gearbox_tx_sched
    import gearbox_pkg::*;
#(
    parameter logic [GB_IN_W-1:0] IDLE_WORD = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               USER_CLK,
    input  logic               SYSTEM_RESET,
    input  logic               ENABLE,
    input  logic [GB_IN_W-1:0] S_DATA,
    input  logic               S_VALID,
    output logic               S_READY,
    output logic [GB_IN_W-1:0] GB_DATA,
    output logic               GB_DATA_VALID,
    output logic               GB_RESET,
    output logic               BUSY,
    output logic [CNT_W-1:0]   UNDERRUN_CNT,
    output logic [CNT_W-1:0]   LOAD_CNT
);

    gb_state_e          state_q, state_d;
    logic               tail_q, tail_d;
    logic [GB_IN_W-1:0] gb_data_q, gb_data_d;
    logic               gb_valid_q, gb_valid_d;
    logic               gb_reset_q, gb_reset_d;
    logic               lvl_clr, lvl_load, lvl_drain;
    logic               lvl_slot_ok, lvl_empty;
    logic               slot;

    gearbox_lvl_tracker u_lvl (
        .clk_i     (USER_CLK),
        .rst_i     (SYSTEM_RESET),
        .clr_i     (lvl_clr),
        .load_i    (lvl_load),
        .drain_i   (lvl_drain),
        .slot_ok_o (lvl_slot_ok),
        .empty_o   (lvl_empty)
    );

    assign slot = (state_q == RUN) && ENABLE && lvl_slot_ok;

    always_comb begin
        state_d    = state_q;
        tail_d     = 1'b0;
        gb_data_d  = gb_data_q;
        gb_valid_d = 1'b0;
        gb_reset_d = gb_reset_q;
        lvl_clr    = 1'b0;
        lvl_load   = 1'b0;
        lvl_drain  = 1'b0;
        case (state_q)
            DISABLED: begin
                lvl_clr = 1'b1;
                if (ENABLE) begin
                    state_d    = RUN;
                    gb_reset_d = 1'b0;
                end else begin
                    gb_reset_d = 1'b1;
                end
            end
            RUN: begin
                gb_reset_d = 1'b0;
                if (!ENABLE) begin
                    lvl_drain = 1'b1;
                    state_d   = DRAIN;
                end else if (slot) begin
                    lvl_load   = 1'b1;
                    gb_valid_d = 1'b1;
                    gb_data_d  = S_VALID ? S_DATA : IDLE_WORD;
                end else begin
                    lvl_drain = 1'b1;
                end
            end
            DRAIN: begin
                lvl_drain = 1'b1;
                // Two empty cycles flush the output register and gearbox storage; the
                // exit edge raises GB_RESET so an immediate re-enable still realigns the pointer.
                if (lvl_empty) begin
                    if (tail_q) begin
                        state_d    = DISABLED;
                        gb_reset_d = 1'b1;
                    end else begin
                        tail_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = DISABLED;
            end
        endcase
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q    <= DISABLED;
            tail_q     <= 1'b0;
            gb_data_q  <= '0;
            gb_valid_q <= 1'b0;
            gb_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            gb_data_q  <= gb_data_d;
            gb_valid_q <= gb_valid_d;
            gb_reset_q <= gb_reset_d;
        end
    end

    assign S_READY       = slot;
    assign GB_DATA       = gb_data_q;
    assign GB_DATA_VALID = gb_valid_q;
    assign GB_RESET      = gb_reset_q;
    assign BUSY          = (state_q != DISABLED);

`ifdef GEARBOX_SCHED_STATS_EN
    logic [CNT_W-1:0] load_cnt_q;
    logic [CNT_W-1:0] underrun_cnt_q;

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            load_cnt_q     <= '0;
            underrun_cnt_q <= '0;
        end else if (slot) begin
            load_cnt_q <= load_cnt_q + 1'b1;
            if (!S_VALID && (underrun_cnt_q != '1)) begin
                underrun_cnt_q <= underrun_cnt_q + 1'b1;
            end
        end
    end

    assign LOAD_CNT     = load_cnt_q;
    assign UNDERRUN_CNT = underrun_cnt_q;
`else
    assign LOAD_CNT     = '0;
    assign UNDERRUN_CNT = '0;
`endif

endmodule
